// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared core package: branch funct3 encodings, resolve FSM states, widths.
package core_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int ILEN_B_DEF = 4;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef enum logic [1:0] {
        BR_IDLE,
        BR_RESULT,
        BR_REDIR
    } br_state_e;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Issue-side uop bus, result pulse and fetch redirect handshake.
// slave = the branch resolve controller, master = issue/fetch side.
interface branch_resolve_ctrl_if #(parameter int XLEN = 32);

    logic            in_valid_i;
    logic            in_ready_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] imm_i;
    logic            pred_taken_i;
    logic [XLEN-1:0] pred_target_i;
    logic            flush_i;
    logic            res_valid_o;
    logic            res_taken_o;
    logic            res_mispredict_o;
    logic            res_illegal_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            redirect_ready_i;

    modport slave (
        input  in_valid_i, op_i, rs1_data_i, rs2_data_i, pc_i, imm_i,
               pred_taken_i, pred_target_i, flush_i, redirect_ready_i,
        output in_ready_o, res_valid_o, res_taken_o, res_mispredict_o,
               res_illegal_o, redirect_valid_o, redirect_pc_o
    );

    modport master (
        output in_valid_i, op_i, rs1_data_i, rs2_data_i, pc_i, imm_i,
               pred_taken_i, pred_target_i, flush_i, redirect_ready_i,
        input  in_ready_o, res_valid_o, res_taken_o, res_mispredict_o,
               res_illegal_o, redirect_valid_o, redirect_pc_o
    );

endinterface

// File: rtl/branch_resolve_ctrl_cond_eval.sv
// branch_cond_eval: combinational branch condition from funct3 and operands.
// Odd funct3 inverts the base test; 010/011 are flagged illegal and never taken.
module branch_cond_eval
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            taken_o,
    output logic            illegal_o
);

    logic base;

    // Select base test by op class, then apply the odd-funct3 inversion
    always_comb begin
        base      = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            BR_EQ,  BR_NE:  base = (rs1_i == rs2_i);
            BR_LT,  BR_GE:  base = ($signed(rs1_i) < $signed(rs2_i));
            BR_LTU, BR_GEU: base = (rs1_i < rs2_i);
            default:        illegal_o = 1'b1;
        endcase
        taken_o = illegal_o ? 1'b0 : (base ^ op_i[0]);
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolution controller: evaluates the branch, checks the
// front-end prediction, pulses the result and runs the fetch redirect handshake.
// Optional BRANCH_STATS_EN adds saturating branch / mispredict counters.
module branch_resolve_ctrl
    import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ILEN_B = ILEN_B_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    branch_resolve_ctrl_if.slave  bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]           stat_branches_o,
    output logic [31:0]           stat_mispred_o
`endif
);

    localparam logic [XLEN-1:0] INC = XLEN'(ILEN_B);

    br_state_e       state_q, state_d;
    logic            taken_q, taken_d;
    logic            mispred_q, mispred_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;

    logic            ev_taken, ev_illegal, ev_mispred;
    logic [XLEN-1:0] ev_next_pc;
    logic            in_result, in_redir, accept;

    branch_cond_eval #(.XLEN(XLEN)) u_cond (
        .op_i      (bus.op_i),
        .rs1_i     (bus.rs1_data_i),
        .rs2_i     (bus.rs2_data_i),
        .taken_o   (ev_taken),
        .illegal_o (ev_illegal)
    );

    // Resolved next PC and prediction check for the uop on the input bus
    always_comb begin
        ev_next_pc = ev_taken ? (bus.pc_i + bus.imm_i) : (bus.pc_i + INC);
        ev_mispred = ~ev_illegal &
                     ((ev_taken != bus.pred_taken_i) |
                      (ev_taken & bus.pred_taken_i & (ev_next_pc != bus.pred_target_i)));
    end

    // Outputs decode from registered state so they are glitch-free towards fetch
    always_comb begin
        in_result            = (state_q == BR_RESULT);
        in_redir             = (state_q == BR_REDIR);
        bus.res_valid_o      = in_result;
        bus.res_taken_o      = in_result & taken_q;
        bus.res_mispredict_o = in_result & mispred_q;
        bus.res_illegal_o    = in_result & illegal_q;
        bus.redirect_valid_o = (in_result & mispred_q) | in_redir;
        bus.redirect_pc_o    = bus.redirect_valid_o ? redir_pc_q : '0;
        bus.in_ready_o       = ~rst_i & ~bus.flush_i &
                               ((state_q == BR_IDLE) | (in_result & ~mispred_q));
        accept               = bus.in_valid_i & bus.in_ready_o;
    end

    // Next state: capture on accept, otherwise walk result -> redirect -> idle; flush wins
    always_comb begin
        state_d    = state_q;
        taken_d    = taken_q;
        mispred_d  = mispred_q;
        illegal_d  = illegal_q;
        redir_pc_d = redir_pc_q;
        if (accept) begin
            state_d    = BR_RESULT;
            taken_d    = ev_taken;
            mispred_d  = ev_mispred;
            illegal_d  = ev_illegal;
            redir_pc_d = ev_next_pc;
        end else begin
            case (state_q)
                BR_RESULT: state_d = (mispred_q & ~bus.redirect_ready_i) ? BR_REDIR : BR_IDLE;
                BR_REDIR:  state_d = bus.redirect_ready_i ? BR_IDLE : BR_REDIR;
                default:   state_d = BR_IDLE;
            endcase
        end
        if (bus.flush_i) begin
            state_d = BR_IDLE;
        end
    end

    // FSM and result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= BR_IDLE;
            taken_q    <= 1'b0;
            mispred_q  <= 1'b0;
            illegal_q  <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            taken_q    <= taken_d;
            mispred_q  <= mispred_d;
            illegal_q  <= illegal_d;
            redir_pc_q <= redir_pc_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mp_cnt_q, mp_cnt_d;

    // Saturating counters, cleared by reset only
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (bus.res_valid_o && br_cnt_q != 32'hFFFF_FFFF) br_cnt_d = br_cnt_q + 32'd1;
        if (bus.res_mispredict_o && mp_cnt_q != 32'hFFFF_FFFF) mp_cnt_d = mp_cnt_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign stat_branches_o = br_cnt_q;
    assign stat_mispred_o  = mp_cnt_q;
`endif

endmodule
